// File: rtl/debug_baud_sync_tx.sv
// Debug-link sync transmitter: passes uart_tx to the pad when idle, emits a burst of 8N1 sync
// characters at a bit period of div*32 clk on request. Optional DEBUG_SYNC_BREAK_EN adds break+mark.
module debug_baud_sync_tx #(
   parameter int unsigned SYNC_CHARS = 4,
   parameter logic [7:0]  SYNC_BYTE  = 8'h55,
   parameter int unsigned GAP_BITS   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] div,
   input  logic       uart_tx,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       err
);

`ifdef DEBUG_SYNC_BREAK_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_FIN, S_BREAK, S_MARK
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_FIN
   } state_e;
`endif

   localparam logic [3:0] CHAR_LAST = 4'(SYNC_CHARS);
   localparam bit         GAP_EN    = (GAP_BITS != 0);
   localparam logic [2:0] GAP_LAST  = GAP_EN ? 3'(GAP_BITS - 1) : 3'd0;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [12:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [2:0]  gap_cnt_q, gap_cnt_d;
   logic [3:0]  char_cnt_q, char_cnt_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
`ifdef DEBUG_SYNC_BREAK_EN
   logic [3:0]  brk_cnt_q, brk_cnt_d;
`endif

   logic [12:0] bit_last;
   logic        bit_end;
   logic        char_end;
   logic [3:0]  char_inc;

   // div_q is never 0 while the timer runs, so bit_last cannot wrap.
   assign bit_last = {div_q, 5'b0} - 13'd1;
   assign bit_end  = (bit_cnt_q == bit_last);
   assign char_inc = char_cnt_q + 4'd1;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      gap_cnt_d  = gap_cnt_q;
      char_cnt_d = char_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      char_end   = 1'b0;
      tx_d       = 1'b1;
`ifdef DEBUG_SYNC_BREAK_EN
      brk_cnt_d  = brk_cnt_q;
`endif

      if (state_q != S_IDLE && state_q != S_FIN) begin
         bit_cnt_d = bit_end ? 13'd0 : bit_cnt_q + 13'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (div != 8'd0) begin
                  div_d      = div;
                  busy_d     = 1'b1;
                  bit_cnt_d  = 13'd0;
                  bit_idx_d  = 3'd0;
                  gap_cnt_d  = 3'd0;
                  char_cnt_d = 4'd0;
`ifdef DEBUG_SYNC_BREAK_EN
                  brk_cnt_d  = 4'd0;
                  state_d    = S_BREAK;
`else
                  state_d    = S_START;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
`ifdef DEBUG_SYNC_BREAK_EN
         S_BREAK: begin
            if (bit_end) begin
               if (brk_cnt_q == 4'd11) begin
                  brk_cnt_d = 4'd0;
                  state_d   = S_MARK;
               end else begin
                  brk_cnt_d = brk_cnt_q + 4'd1;
               end
            end
         end
         S_MARK: begin
            if (bit_end) begin
               if (brk_cnt_q == 4'd1) begin
                  state_d = S_START;
               end else begin
                  brk_cnt_d = brk_cnt_q + 4'd1;
               end
            end
         end
`endif
         S_START: begin
            if (bit_end) begin
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (GAP_EN) begin
                  gap_cnt_d = 3'd0;
                  state_d   = S_GAP;
               end else begin
                  char_end = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (bit_end) begin
               if (gap_cnt_q == GAP_LAST) begin
                  char_end = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 3'd1;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      if (char_end) begin
         char_cnt_d = char_inc;
         state_d    = (char_inc == CHAR_LAST) ? S_FIN : S_START;
      end

      // The line bit is derived from the next state so tx_q lines up with state_q.
      unique case (state_d)
         S_IDLE:  tx_d = uart_tx;
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = SYNC_BYTE[bit_idx_d];
`ifdef DEBUG_SYNC_BREAK_EN
         S_BREAK: tx_d = 1'b0;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignments.
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= 8'd0;
         bit_cnt_q  <= 13'd0;
         bit_idx_q  <= 3'd0;
         gap_cnt_q  <= 3'd0;
         char_cnt_q <= 4'd0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef DEBUG_SYNC_BREAK_EN
         brk_cnt_q  <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         gap_cnt_q  <= gap_cnt_d;
         char_cnt_q <= char_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef DEBUG_SYNC_BREAK_EN
         brk_cnt_q  <= brk_cnt_d;
`endif
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule
